// File: rtl/net_pkg.sv
// Shared definitions for the net_* datapath and its downstream stages.
package net_pkg;

  localparam int unsigned NET_T = 16;
  localparam int unsigned NET_M = 16;

  typedef logic signed [NET_T-1:0] data_t;

  // Width needed to hold an index 0..m-1; a single bit for m<=2.
  function automatic int unsigned idx_width(input int unsigned m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/argmax_result_reg.sv
// One-entry result holding register with a valid/ready output side.
// A load always wins; it may coincide with the drain of the previous entry.
module argmax_result_reg
  import net_pkg::*;
#(
  parameter int unsigned W  = NET_T,
  parameter int unsigned IW = idx_width(NET_M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [IW-1:0] i_index,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [IW-1:0] o_index
);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [IW-1:0] r_index;

  // Load a new result, or release the slot when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_index <= i_index;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_index = r_index;

endmodule

// File: rtl/vec_argmax_stream.sv
// Streaming argmax: consumes M signed elements per vector, emits the
// maximum and its position. Ties resolve to the lowest index.
module vec_argmax_stream
  import net_pkg::*;
#(
  parameter int unsigned T  = NET_T,
  parameter int unsigned M  = NET_M,
  parameter int unsigned IW = idx_width(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data,
  output logic [IW-1:0]       output_index
);

  localparam logic [IW-1:0] LAST = IW'(M - 1);

  logic [IW-1:0]       r_cnt;
  logic signed [T-1:0] r_best_val;
  logic [IW-1:0]       r_best_idx;

  logic                w_last;
  logic                w_in_xfer;
  logic                w_take;
  logic signed [T-1:0] w_new_val;
  logic [IW-1:0]       w_new_idx;
  logic                w_out_valid;
  logic [T-1:0]        w_out_data;

  assign w_last    = (r_cnt == LAST);
  assign w_in_xfer = input_valid && input_ready;
  // Element 0 always reloads; later elements need a strictly larger value.
  assign w_take    = (r_cnt == '0) || (input_data > r_best_val);
  assign w_new_val = w_take ? input_data : r_best_val;
  assign w_new_idx = w_take ? r_cnt : r_best_idx;

  // Only the completing element can stall, and only when the slot is stuck.
  assign input_ready = !(w_last && w_out_valid && !output_ready);

  // Element counter and running maximum for the vector in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (w_in_xfer) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt      <= r_cnt + 1'b1;
        r_best_val <= w_new_val;
        r_best_idx <= w_new_idx;
      end
    end
  end

  argmax_result_reg #(
    .W  (T),
    .IW (IW)
  ) u_result (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_in_xfer && w_last),
    .i_data  (w_new_val),
    .i_index (w_new_idx),
    .i_ready (output_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_data),
    .o_index (output_index)
  );

  assign output_valid = w_out_valid;
  assign output_data  = $signed(w_out_data);

endmodule
